ps2_scan_rx: RTL and testbench

- PS/2 keyboard receiver.
- Samples the asynchronous PS/2 clock and data lines, frames 11-bit packets and checks odd parity and the stop bit.
- Decodes the F0 (break) and E0 (extended) prefixes.
- Holds the last make code on oKEY; each nibble of oKEY drives one hex 7-segment decoder downstream.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_scan_rx_if.sv | 8 +
 rtl/ps2_sync_edge.sv | 40 ++++
 rtl/ps2_scan_rx.sv | 178 +++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;
    localparam int         PS2_SYNC_MIN   = 2;

    // Odd parity over data+parity, and the stop bit must be high.
    function automatic logic frame_good(input logic [7:0] d, input logic p, input logic stop);
        return (^{d, p}) & stop;
    endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// PS/2 line pair: the device side drives both lines, the receiver only observes them.
interface ps2_scan_rx_if;
    logic ps2_clk;
    logic ps2_dat;

    modport master (output ps2_clk, output ps2_dat);
    modport slave  (input  ps2_clk, input  ps2_dat);
endinterface

// File: rtl/ps2_sync_edge.sv
// Synchronises raw PS/2 clock/data and flags PS/2 clock falling edges.
// Latency: fall_o rises SYNC_STAGES+1 cycles after the pin falls.
// Backpressure: none, free-running strobe.
module ps2_sync_edge
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ps2_scan_rx_if.slave pins,
    output logic         dat_o,
    output logic         fall_o
);
    localparam int N = (SYNC_STAGES < PS2_SYNC_MIN) ? PS2_SYNC_MIN : SYNC_STAGES;

    logic [N-1:0] clk_sync_q;
    logic [N-1:0] dat_sync_q;
    logic         clk_prev_q;
    logic         fall_q;

    // Flops reset high so an idle bus never produces a spurious edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[N-2:0], pins.ps2_clk};
            dat_sync_q <= {dat_sync_q[N-2:0], pins.ps2_dat};
            clk_prev_q <= clk_sync_q[N-1];
            fall_q     <= clk_prev_q & ~clk_sync_q[N-1];
        end
    end

    assign dat_o  = dat_sync_q[N-1];
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames 11-bit packets, checks parity/stop, decodes F0/E0 prefixes.
// Latency: outputs update the cycle after the stop-bit edge is detected.
// Backpressure: none, results are pulses and held registers.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic [7:0] oSCAN,
    output logic       oVALID,
    output logic       oERR,
    output logic [7:0] oKEY,
    output logic       oKEY_VALID,
    output logic       oBREAK,
    output logic       oEXT
);
    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam int            DATA_BITS = PS2_FRAME_BITS - 3;
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    ps2_scan_rx_if pins ();
    assign pins.ps2_clk = iPS2_CLK;
    assign pins.ps2_dat = iPS2_DAT;

    logic dat_s;
    logic fall_s;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (iCLK),
        .rst_i  (iRST),
        .pins   (pins),
        .dat_o  (dat_s),
        .fall_o (fall_s)
    );

    ps2_state_e    state_q,    state_d;
    logic [2:0]    bitcnt_q,   bitcnt_d;
    logic [7:0]    shift_q,    shift_d;
    logic          par_q,      par_d;
    logic [TW-1:0] tmo_q,      tmo_d;
    logic          brk_pend_q, brk_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic [7:0]    scan_q,     scan_d;
    logic [7:0]    key_q,      key_d;
    logic          vld_q,      vld_d;
    logic          err_q,      err_d;
    logic          kvld_q,     kvld_d;
    logic          brk_q,      brk_d;
    logic          ext_q,      ext_d;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        scan_d     = scan_q;
        key_d      = key_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        vld_d      = 1'b0;
        err_d      = 1'b0;
        kvld_d     = 1'b0;

        if (fall_s) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d  = {dat_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (frame_good(shift_q, par_q, dat_s)) begin
                        scan_d = shift_q;
                        vld_d  = 1'b1;
                        if (shift_q == PS2_BREAK) begin
                            brk_pend_d = 1'b1;
                        end else if (shift_q == PS2_EXT) begin
                            ext_pend_d = 1'b1;
                        end else begin
                            brk_d      = brk_pend_q;
                            ext_d      = ext_pend_q;
                            kvld_d     = 1'b1;
                            key_d      = brk_pend_q ? key_q : shift_q;
                            brk_pend_d = 1'b0;
                            ext_pend_d = 1'b0;
                        end
                    end else begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // An edge in the timeout cycle restarts the count instead of aborting.
        if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (fall_s) begin
            tmo_d = '0;
        end else if (tmo_q == TO_LAST) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
            bitcnt_d   = 3'd0;
            tmo_d      = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            scan_q     <= 8'd0;
            key_q      <= 8'd0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            kvld_q     <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            scan_q     <= scan_d;
            key_q      <= key_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            kvld_q     <= kvld_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
        end
    end

    assign oSCAN      = scan_q;
    assign oVALID     = vld_q;
    assign oERR       = err_q;
    assign oKEY       = key_q;
    assign oKEY_VALID = kvld_q;
    assign oBREAK     = brk_q;
    assign oEXT       = ext_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: directed table, hand-built reset/timeout sequences, random frames vs a frame-level model.
module tb_ps2_scan_rx;
    import ps2_pkg::*;

    localparam int SYNC = 2;
    localparam int TMO  = 300;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_scan_rx_if ps2 ();

    logic [7:0] oSCAN, oKEY;
    logic       oVALID, oERR, oKEY_VALID, oBREAK, oEXT;

    ps2_scan_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iPS2_CLK   (ps2.ps2_clk),
        .iPS2_DAT   (ps2.ps2_dat),
        .oSCAN      (oSCAN),
        .oVALID     (oVALID),
        .oERR       (oERR),
        .oKEY       (oKEY),
        .oKEY_VALID (oKEY_VALID),
        .oBREAK     (oBREAK),
        .oEXT       (oEXT)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observed pulses, sampled on the falling edge of the system clock.
    int         vld_cnt = 0, kv_cnt = 0, err_cnt = 0;
    logic [7:0] got_scan[$];
    logic [9:0] got_ev[$];
    logic       vld_p = 1'b0, kv_p = 1'b0, err_p = 1'b0;

    always @(negedge clk) begin
        if (oVALID) begin
            check("vld_one_cycle", vld_p, 0);
            vld_cnt++;
            got_scan.push_back(oSCAN);
        end
        if (oKEY_VALID) begin
            check("kv_one_cycle", kv_p, 0);
            kv_cnt++;
            got_ev.push_back({oKEY, oBREAK, oEXT});
        end
        if (oERR) begin
            check("err_one_cycle", err_p, 0);
            err_cnt++;
        end
        vld_p = oVALID;
        kv_p  = oKEY_VALID;
        err_p = oERR;
    end

    // Frame-level reference: collects the bits seen at each PS/2 clock fall.
    bit         m_active = 1'b0;
    bit         m_bits[$];
    logic [7:0] m_scan = 8'd0, m_key = 8'd0;
    logic       m_brk = 1'b0, m_ext = 1'b0, m_bp = 1'b0, m_ep = 1'b0;
    logic [7:0] exp_scan[$];
    logic [9:0] exp_ev[$];
    int         exp_err = 0;

    function automatic void model_bit(input bit b);
        logic [7:0] v;
        if (!m_active) begin
            if (b == 1'b0) begin
                m_active = 1'b1;
                m_bits.delete();
            end
            return;
        end
        m_bits.push_back(b);
        if (m_bits.size() < 10) return;
        m_active = 1'b0;
        for (int i = 0; i < 8; i++) v[i] = m_bits[i];
        if ((($countones(v) + int'(m_bits[8])) % 2 == 1) && m_bits[9]) begin
            m_scan = v;
            exp_scan.push_back(v);
            if (v == 8'hF0) m_bp = 1'b1;
            else if (v == 8'hE0) m_ep = 1'b1;
            else begin
                m_brk = m_bp;
                m_ext = m_ep;
                if (!m_bp) m_key = v;
                exp_ev.push_back({m_key, m_brk, m_ext});
                m_bp = 1'b0;
                m_ep = 1'b0;
            end
        end else begin
            exp_err++;
            m_bp = 1'b0;
            m_ep = 1'b0;
        end
    endfunction

    function automatic void model_gap();
        if (m_active) begin
            exp_err++;
            m_active = 1'b0;
            m_bp = 1'b0;
            m_ep = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_active = 1'b0;
        m_scan = 8'd0; m_key = 8'd0;
        m_brk = 1'b0; m_ext = 1'b0; m_bp = 1'b0; m_ep = 1'b0;
        exp_scan.delete(); exp_ev.delete(); got_scan.delete(); got_ev.delete();
        exp_err = err_cnt;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".scan"}, oSCAN, m_scan);
        check({tag, ".key"}, oKEY, m_key);
        check({tag, ".brk"}, oBREAK, m_brk);
        check({tag, ".ext"}, oEXT, m_ext);
        check({tag, ".errs"}, err_cnt, exp_err);
        check({tag, ".n_scan"}, got_scan.size(), exp_scan.size());
        check({tag, ".n_ev"}, got_ev.size(), exp_ev.size());
        while (got_scan.size() > 0 && exp_scan.size() > 0)
            check({tag, ".scan_q"}, got_scan.pop_front(), exp_scan.pop_front());
        while (got_ev.size() > 0 && exp_ev.size() > 0)
            check({tag, ".ev_q"}, got_ev.pop_front(), exp_ev.pop_front());
        got_scan.delete(); exp_scan.delete(); got_ev.delete(); exp_ev.delete();
    endtask

    task automatic send_bit(input bit b);
        ps2.ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2.ps2_clk = 1'b0;
        model_bit(b);
        repeat (HALF) @(negedge clk);
        ps2.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] v, input bit pflip, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit((~^v) ^ pflip);
        send_bit(stop);
        ps2.ps2_dat = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Start bit plus n data-slot bits, then the lines idle past the timeout.
    task automatic send_partial(input logic [9:0] bits, input int n);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
        ps2.ps2_dat = 1'b1;
        repeat (TMO + 40) @(negedge clk);
        model_gap();
    endtask

    typedef struct {
        logic [7:0] b;
        bit         pflip;
        bit         stop;
        logic [7:0] scan;
        logic [7:0] key;
        bit         brk;
        bit         ext;
        int         vld;
        int         kv;
        int         err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int v0, k0, e0;
        logic [7:0] rb;

        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 8'h1C, 1'b0, 1'b0, 1, 1, 0};
        tbl[1]  = '{8'hF0, 1'b0, 1'b1, 8'hF0, 8'h1C, 1'b0, 1'b0, 1, 0, 0};
        tbl[2]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 8'h1C, 1'b1, 1'b0, 1, 1, 0};
        tbl[3]  = '{8'h29, 1'b0, 1'b1, 8'h29, 8'h29, 1'b0, 1'b0, 1, 1, 0};
        tbl[4]  = '{8'hE0, 1'b0, 1'b1, 8'hE0, 8'h29, 1'b0, 1'b0, 1, 0, 0};
        tbl[5]  = '{8'h75, 1'b0, 1'b1, 8'h75, 8'h75, 1'b0, 1'b1, 1, 1, 0};
        tbl[6]  = '{8'hE0, 1'b0, 1'b1, 8'hE0, 8'h75, 1'b0, 1'b1, 1, 0, 0};
        tbl[7]  = '{8'hF0, 1'b0, 1'b1, 8'hF0, 8'h75, 1'b0, 1'b1, 1, 0, 0};
        tbl[8]  = '{8'h75, 1'b0, 1'b1, 8'h75, 8'h75, 1'b1, 1'b1, 1, 1, 0};
        tbl[9]  = '{8'hF0, 1'b0, 1'b1, 8'hF0, 8'h75, 1'b1, 1'b1, 1, 0, 0};
        tbl[10] = '{8'h1C, 1'b1, 1'b1, 8'hF0, 8'h75, 1'b1, 1'b1, 0, 0, 1};
        tbl[11] = '{8'h1C, 1'b0, 1'b0, 8'hF0, 8'h75, 1'b1, 1'b1, 0, 0, 1};
        tbl[12] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 8'h1C, 1'b0, 1'b0, 1, 1, 0};

        rst = 1'b1;
        ps2.ps2_clk = 1'b1;
        ps2.ps2_dat = 1'b1;
        repeat (4) @(negedge clk);
        check("rst.scan", oSCAN, 0);
        check("rst.key", oKEY, 0);
        check("rst.vld", oVALID, 0);
        check("rst.err", oERR, 0);
        check("rst.kv", oKEY_VALID, 0);
        check("rst.brk", oBREAK, 0);
        check("rst.ext", oEXT, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            v0 = vld_cnt; k0 = kv_cnt; e0 = err_cnt;
            send_frame(tbl[i].b, tbl[i].pflip, tbl[i].stop);
            check($sformatf("tbl%0d.scan", i), oSCAN, tbl[i].scan);
            check($sformatf("tbl%0d.key", i), oKEY, tbl[i].key);
            check($sformatf("tbl%0d.brk", i), oBREAK, tbl[i].brk);
            check($sformatf("tbl%0d.ext", i), oEXT, tbl[i].ext);
            check($sformatf("tbl%0d.vld", i), vld_cnt - v0, tbl[i].vld);
            check($sformatf("tbl%0d.kv", i), kv_cnt - k0, tbl[i].kv);
            check($sformatf("tbl%0d.err", i), err_cnt - e0, tbl[i].err);
        end
        check_model("tbl");

        // Timeout: pending F0, then start + 5 bits of 0x29 and silence.
        send_frame(8'hF0, 1'b0, 1'b1);
        v0 = vld_cnt; e0 = err_cnt;
        send_partial(10'h029, 5);
        check("tmo.err", err_cnt - e0, 1);
        check("tmo.vld", vld_cnt - v0, 0);
        send_frame(8'h29, 1'b0, 1'b1);
        check("tmo.scan", oSCAN, 8'h29);
        check("tmo.key", oKEY, 8'h29);
        check("tmo.brk", oBREAK, 0);
        check_model("tmo");

        // Reset after the 4th data bit of 0x1C; the leftover bits are also fed.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(tbl[0].b[i]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmid.scan", oSCAN, 0);
        check("rmid.key", oKEY, 0);
        check("rmid.vld", oVALID, 0);
        check("rmid.err", oERR, 0);
        model_reset();
        for (int i = 4; i < 8; i++) send_bit(tbl[0].b[i]);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (TMO + 40) @(negedge clk);
        model_gap();
        send_frame(8'h1C, 1'b0, 1'b1);
        check("rmid.scan2", oSCAN, 8'h1C);
        check("rmid.key2", oKEY, 8'h1C);
        check_model("rmid");

        // Reset covering the cycle in which the stop edge is consumed.
        v0 = vld_cnt; k0 = kv_cnt; e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(tbl[3].b[i]);
        send_bit(1'b0);
        ps2.ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2.ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
        check("rstop.vld", vld_cnt - v0, 0);
        check("rstop.kv", kv_cnt - k0, 0);
        check("rstop.err", err_cnt - e0, 0);
        check("rstop.scan", oSCAN, 0);
        check("rstop.key", oKEY, 0);
        send_frame(8'h29, 1'b0, 1'b1);
        check("rstop.scan2", oSCAN, 8'h29);
        check_model("rstop");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 99) < 5) begin
                send_partial(10'($urandom), $urandom_range(0, 9));
            end else begin
                case ($urandom_range(0, 9))
                    0, 1:    rb = 8'hF0;
                    2:       rb = 8'hE0;
                    default: rb = 8'($urandom);
                endcase
                send_frame(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 19) != 0);
            end
            check_model($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
